// File: rtl/ad9467fmc_pkg.sv
// Shared definitions for the AD9467 FMC sample path: source modes, lane geometry
// and a saturating counter helper.
package ad9467fmc_pkg;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_ZERO   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam int LANES    = 4;
  localparam int SAMPLE_W = 16;
  localparam int LANE_W   = $clog2(LANES);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [SAMPLE_W-1:0] sat_inc(input logic [SAMPLE_W-1:0] value);
    return (&value) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with registered count and registered head-of-queue read.
// The head word is prefetched so rd_data always shows the oldest stored word;
// a word written this cycle becomes visible (count and data) on the next cycle.
module sync_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] rd_data_reg;

  // Next read pointer and occupancy; a flush rewinds both pointers.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (reset || flush) begin
      rd_ptr_next = '0;
    end else if (rd_en) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage array, written without reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_ptr_reg] <= wr_data;
    end
  end

  // Registered head read; forwards a word landing on the next head slot.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_ptr_reg == rd_ptr_next)) begin
      rd_data_reg <= wr_data;
    end else begin
      rd_data_reg <= mem_reg[rd_ptr_next];
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign rd_data = rd_data_reg;
  assign count   = count_reg;

endmodule

// File: rtl/axis_sample_unpacker.sv
// Buffers 64-bit AXI-Stream words and hands out one 16-bit {q,i} sample per
// sample_ce request, four lanes per word, with ramp and zero test sources.
module axis_sample_unpacker
  import ad9467fmc_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int DEPTH               = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [1:0]                     mode,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic                           sample_ce,
  output logic [SAMPLE_W-1:0]            sample_data,
  output logic                           sample_valid,
  output logic                           underflow,
  output logic [15:0]                    underflow_count,
  output logic [$clog2(DEPTH):0]         fill
);

  localparam int FW = $clog2(DEPTH) + 1;
  localparam logic [FW-1:0] DEPTH_W = FW'(DEPTH);

  mode_e                    mode_sel;
  logic [C_S_AXIS_DATA_WIDTH-1:0] head_word;
  logic [SAMPLE_W-1:0]      lane_sample [LANES];
  logic [FW-1:0]            fifo_count;
  logic                     push;
  logic                     pop;
  logic                     flush;
  logic                     unused_tlast;

  logic                     ready_en_reg;
  logic [LANE_W-1:0]        lane_reg,            lane_next;
  logic [SAMPLE_W-1:0]      ramp_reg,            ramp_next;
  logic [SAMPLE_W-1:0]      sample_data_reg,     sample_data_next;
  logic                     sample_valid_reg,    sample_valid_next;
  logic                     underflow_reg,       underflow_next;
  logic [15:0]              underflow_count_reg, underflow_count_next;

  assign mode_sel     = mode_e'(mode);
  assign unused_tlast = s_axis_tlast;

  // Ready only once out of reset, while running, and with a free slot.
  assign s_axis_tready = enable && ready_en_reg && !reset && (fifo_count < DEPTH_W);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign flush         = !enable;

  sync_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (C_S_AXIS_DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (push),
    .wr_data (s_axis_tdata),
    .rd_en   (pop),
    .rd_data (head_word),
    .count   (fifo_count)
  );

  // Split the head word into its sample lanes.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_sample[gi] = head_word[gi*SAMPLE_W +: SAMPLE_W];
  end

  // Request handling: pick the sample source and advance lane/ramp/pop.
  always_comb begin
    sample_data_next     = sample_data_reg;
    sample_valid_next    = 1'b0;
    underflow_next       = 1'b0;
    lane_next            = lane_reg;
    ramp_next            = ramp_reg;
    pop                  = 1'b0;
    underflow_count_next = underflow_count_reg;

    if (!enable) begin
      lane_next = '0;
      ramp_next = '0;
      if (sample_ce) begin
        sample_valid_next = 1'b1;
        sample_data_next  = '0;
      end
    end else if (sample_ce) begin
      sample_valid_next = 1'b1;
      case (mode_sel)
        MODE_STREAM: begin
          if (fifo_count != '0) begin
            sample_data_next = lane_sample[lane_reg];
            lane_next        = lane_reg + LANE_W'(1);
            pop              = (lane_reg == LANE_W'(LANES - 1));
          end else begin
            sample_data_next = '0;
            underflow_next   = 1'b1;
          end
        end
        MODE_RAMP: begin
          sample_data_next = ramp_reg;
          ramp_next        = ramp_reg + 16'd1;
        end
        default: begin
          sample_data_next = '0;
        end
      endcase
    end

    if (underflow_next) begin
      underflow_count_next = sat_inc(underflow_count_reg);
    end
  end

  // Output and control-state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_en_reg        <= 1'b0;
      lane_reg            <= '0;
      ramp_reg            <= '0;
      sample_data_reg     <= '0;
      sample_valid_reg    <= 1'b0;
      underflow_reg       <= 1'b0;
      underflow_count_reg <= '0;
    end else begin
      ready_en_reg        <= 1'b1;
      lane_reg            <= lane_next;
      ramp_reg            <= ramp_next;
      sample_data_reg     <= sample_data_next;
      sample_valid_reg    <= sample_valid_next;
      underflow_reg       <= underflow_next;
      underflow_count_reg <= underflow_count_next;
    end
  end

  assign sample_data     = sample_data_reg;
  assign sample_valid    = sample_valid_reg;
  assign underflow       = underflow_reg;
  assign underflow_count = underflow_count_reg;
  assign fill            = fifo_count;

endmodule

// File: doc/axis_sample_unpacker.md
AXIS_SAMPLE_UNPACKER -- requirements
Module: axis_sample_unpacker

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 64, AXI-Stream input word width; only 64 is supported.
REQ-002 SHALL have parameter DEPTH, default 4, word-buffer depth in 64-bit words; power of two, at least 2.
REQ-003 SHALL have port clk  in  1  sole clock for all logic.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  run control; low flushes the buffer and blocks input.
REQ-006 SHALL have port mode  in  2  source select: 0 stream, 1 ramp, 2 zero, 3 reserved (treated as zero).
REQ-007 SHALL have port s_axis_tdata  in  64  four packed samples; sample k in bits [16k+15:16k].
REQ-008 SHALL have port s_axis_tvalid  in  1  input word valid.
REQ-009 SHALL have port s_axis_tready  out  1  input word accepted when high together with tvalid.
REQ-010 SHALL have port s_axis_tlast  in  1  ignored.
REQ-011 SHALL have port sample_ce  in  1  one-cycle sample request from the interpolator/DAC side.
REQ-012 SHALL have port sample_data  out  16  {q[7:0], i[7:0]} sample.
REQ-013 SHALL have port sample_valid  out  1  sample_data updated this cycle.
REQ-014 SHALL have port underflow  out  1  one-cycle pulse: a request was served from an empty buffer.
REQ-015 SHALL have port underflow_count  out  16  saturating underflow event count.
REQ-016 SHALL have port fill  out  $clog2(DEPTH)+1  current buffer occupancy in words.

Function
REQ-017 SHALL assert s_axis_tready = enable && (fill < DEPTH), combinationally from registered state.
REQ-018 SHALL write a word into the FIFO on tvalid && tready; the word becomes poppable one cycle later, with no bypass.
REQ-019 SHALL keep a 2-bit lane index selecting the 16-bit sample within the head word, starting at lane 0.
REQ-020 In mode 0, SHALL, on sample_ce with fill > 0, register the head word's lane sample and increment lane; at lane 3 it SHALL also pop the head word and wrap lane to 0.
REQ-021 In mode 0, SHALL, on sample_ce with fill == 0, output 0x0000 with sample_valid high, pulse underflow, and leave lane unchanged.
REQ-022 SHALL keep fill unchanged on a same-cycle push and pop; a push when fill == DEPTH SHALL be impossible because tready is low.
REQ-023 In mode 1, SHALL, on each sample_ce, output a 16-bit ramp that increments by 1 and wraps 0xFFFF->0x0000, without popping the FIFO; the FIFO still fills to DEPTH.
REQ-024 In mode 2 or 3, SHALL output 0x0000 on each sample_ce, with no pop and no underflow.
REQ-025 SHALL present sample_data/sample_valid one cycle after sample_ce (latency 1); sample_valid SHALL be low in cycles without sample_ce, and sample_data SHALL hold its value.
REQ-026 SHALL increment underflow_count by 1 per underflow and hold it at 0xFFFF.
REQ-027 When enable is low, SHALL set fill to 0, lane to 0, ramp to 0, output 0x0000 on sample_ce, and raise no underflow.
REQ-028 SHALL preserve FIFO contents on a mode change, without resetting lane.

Reset
REQ-029 SHALL, in the cycle after reset is high, hold s_axis_tready=0, sample_data=0, sample_valid=0, underflow=0, underflow_count=0, fill=0, lane=0, ramp=0.
REQ-030 SHALL let reset take priority over enable, sample_ce and input handshakes.

Structure
REQ-031 SHALL place mode encodings (MODE_STREAM, MODE_RAMP, MODE_ZERO), the lane count (4) and the sample width (16) in the shared package ad9467fmc_pkg.
REQ-032 SHALL implement the word buffer as one sub-module, sync_word_fifo (DEPTH x 64, registered count, no fall-through).

Verification
REQ-033 Reset check: drive reset high 2 cycles -> all outputs 0; tready rises the cycle after reset falls with enable=1.
REQ-034 Unpack order: push 0x0004_0003_0002_0001, then 4 sample_ce -> sample_data 0x0001, 0x0002, 0x0003, 0x0004, each 1 cycle after its ce; fill 1->0 after the 4th.
REQ-035 Backpressure: push 5 words with no sample_ce -> tready low after 4 accepted, fill=4; one word fully drained -> tready high again.
REQ-036 Underflow: empty buffer plus 3 sample_ce -> three 0x0000 samples, underflow pulses 3 times, underflow_count=3; force 70000 events -> count saturates at 0xFFFF.
REQ-037 Ramp/zero: mode=1, 3 ce -> 0x0000, 0x0001, 0x0002; mode=2 -> 0x0000, with no pop and no underflow.
REQ-038 Enable drop mid-word: after 2 lanes are consumed, enable=0 then 1 -> fill=0, lane=0; the next pushed word starts at lane 0.
